// File: rtl/multicycle_controlunit.sv
// ----------------------------------------------------------------------------
// multicycle_controlunit
//
// Multicycle RV32I control unit. Each instruction is walked through
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. Decoded control fields are
// captured on the DECODE cycle and held until the next DECODE. All write
// strobes are qualified by state. The unit handshakes with instruction fetch
// (instr_valid) and a variable-latency data memory (mem_ready), counts retired
// instructions, and enters a sticky TRAP state on an illegal opcode or a data
// memory timeout. Only rst leaves TRAP.
//
// Optional build macro:
//   RV_M_EXT_EN  - accepts R-type with Funct7=0000001 (M extension). EXEC
//                  pulses mul_start, then MULWAIT holds until mul_done.
//                  When undefined, that encoding is illegal, mul_start is 0
//                  and mul_done is ignored.
//
// Parameters:
//   MEM_TIMEOUT  cycles allowed in MEM before a timeout trap (2..2^CNT_W-1)
//   CNT_W        width of the MEM wait counter
//   RET_W        width of the retired-instruction counter (wraps)
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   OpCode/Funct3/Funct7   instruction fields from IR
//   instr_valid            fetch data valid
//   mem_ready              data memory access complete
//   mul_done               mul/div result valid (M extension only)
//   IRWr, PCWr, RUWr       IR load, PC update, register file write
//   DMWr, DMRd             data memory write / read request
//   ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMCtrl, BrOp, RUDataWrSrc
//                          decoded datapath controls
//   mul_start              1-cycle start pulse to mul/div
//   retire, retired        completion pulse and completion count
//   trap, trap_cause       sticky error flag, 01=illegal opcode, 10=mem timeout
// ----------------------------------------------------------------------------
module multicycle_controlunit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       OpCode,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic             instr_valid,
    input  logic             mem_ready,
    input  logic             mul_done,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RUWr,
    output logic             DMWr,
    output logic             DMRd,
    output logic [3:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             ALUASrc,
    output logic             ALUBSrc,
    output logic [2:0]       DMCtrl,
    output logic [4:0]       BrOp,
    output logic [1:0]       RUDataWrSrc,
    output logic             mul_start,
    output logic             retire,
    output logic [RET_W-1:0] retired,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP,
        S_MULWAIT
    } state_t;

    // Instruction class decides the path taken after EXEC.
    typedef enum logic [2:0] {
        C_ALU,      // R, I-ALU, JAL, JALR, LUI, AUIPC: EXEC -> WB
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_MUL
    } cls_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------------
    // Combinational decode of the IR fields
    // ------------------------------------------------------------------------
    logic [3:0] dec_aluop;
    logic [2:0] dec_immsrc;
    logic       dec_asrc;
    logic       dec_bsrc;
    logic [2:0] dec_dmctrl;
    logic [4:0] dec_brop;
    logic [1:0] dec_wrsrc;
    cls_t       dec_cls;
    logic       dec_legal;

    always_comb begin
        dec_aluop  = '0;
        dec_immsrc = '0;
        dec_asrc   = 1'b0;
        dec_bsrc   = 1'b0;
        dec_dmctrl = '0;
        dec_brop   = '0;
        dec_wrsrc  = '0;
        dec_cls    = C_ALU;
        dec_legal  = 1'b1;
        case (OpCode)
            OP_R: begin
                if (Funct7 == F7_MULDIV) begin
`ifdef RV_M_EXT_EN
                    dec_aluop = {1'b1, Funct3};
                    dec_cls   = C_MUL;
`else
                    dec_legal = 1'b0;
`endif
                end else begin
                    dec_aluop = {Funct7[5], Funct3};
                end
            end
            OP_I: begin
                // Funct7[5] only selects SRAI over SRLI; ignored elsewhere.
                dec_aluop = {(Funct3 == 3'b101) ? Funct7[5] : 1'b0, Funct3};
                dec_bsrc  = 1'b1;
            end
            OP_LOAD: begin
                dec_bsrc   = 1'b1;
                dec_dmctrl = Funct3;
                dec_wrsrc  = 2'b01;
                dec_cls    = C_LOAD;
            end
            OP_STORE: begin
                dec_immsrc = 3'b001;
                dec_bsrc   = 1'b1;
                dec_dmctrl = Funct3;
                dec_cls    = C_STORE;
            end
            OP_BRANCH: begin
                dec_immsrc = 3'b101;
                dec_brop   = {2'b01, Funct3};
                dec_aluop  = 4'b1000;
                dec_cls    = C_BRANCH;
            end
            OP_JAL: begin
                dec_immsrc = 3'b110;
                dec_asrc   = 1'b1;
                dec_bsrc   = 1'b1;
                dec_brop   = 5'b10000;
                dec_wrsrc  = 2'b10;
            end
            OP_JALR: begin
                dec_bsrc  = 1'b1;
                dec_brop  = 5'b10000;
                dec_wrsrc = 2'b10;
            end
            OP_LUI: begin
                dec_immsrc = 3'b010;
                dec_aluop  = 4'b1111;
                dec_bsrc   = 1'b1;
            end
            OP_AUIPC: begin
                dec_immsrc = 3'b010;
                dec_asrc   = 1'b1;
                dec_bsrc   = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

`ifndef RV_M_EXT_EN
    logic unused_mul_done;
    assign unused_mul_done = mul_done;
`endif

    // ------------------------------------------------------------------------
    // Registered control fields, counters, trap status
    // ------------------------------------------------------------------------
    logic [3:0]       aluop_q;
    logic [2:0]       immsrc_q;
    logic             asrc_q;
    logic             bsrc_q;
    logic [2:0]       dmctrl_q;
    logic [4:0]       brop_q;
    logic [1:0]       wrsrc_q;
    cls_t             cls_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RET_W-1:0] retired_q;
    logic             trap_q;
    logic [1:0]       cause_q;

    logic             trap_set;
    logic [1:0]       trap_cause_d;

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        trap_set     = 1'b0;
        trap_cause_d = '0;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d      = S_TRAP;
                    trap_set     = 1'b1;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = S_FETCH;
`ifdef RV_M_EXT_EN
                    C_MUL:           state_d = S_MULWAIT;
`endif
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // A ready on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_TRAP;
                    trap_set     = 1'b1;
                    trap_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_MULWAIT: begin
`ifdef RV_M_EXT_EN
                if (mul_done) begin
                    state_d = S_WB;
                end
`else
                state_d = S_FETCH;
`endif
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs
    // During DECODE the fields come straight from the decoder so the datapath
    // sees them one cycle earlier; afterwards the captured copy is held.
    // ------------------------------------------------------------------------
    always_comb begin
        IRWr      = 1'b0;
        PCWr      = 1'b0;
        RUWr      = 1'b0;
        DMWr      = 1'b0;
        DMRd      = 1'b0;
        mul_start = 1'b0;
        retire    = 1'b0;

        if (state_q == S_DECODE) begin
            ALUOp       = dec_aluop;
            ImmSrc      = dec_immsrc;
            ALUASrc     = dec_asrc;
            ALUBSrc     = dec_bsrc;
            DMCtrl      = dec_dmctrl;
            BrOp        = dec_brop;
            RUDataWrSrc = dec_wrsrc;
        end else begin
            ALUOp       = aluop_q;
            ImmSrc      = immsrc_q;
            ALUASrc     = asrc_q;
            ALUBSrc     = bsrc_q;
            DMCtrl      = dmctrl_q;
            BrOp        = brop_q;
            RUDataWrSrc = wrsrc_q;
        end

        case (state_q)
            S_FETCH: begin
                IRWr = instr_valid;
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    PCWr   = 1'b1;
                    retire = 1'b1;
                end
`ifdef RV_M_EXT_EN
                mul_start = (cls_q == C_MUL);
`endif
            end
            S_MEM: begin
                DMRd = (cls_q == C_LOAD);
                DMWr = (cls_q == C_STORE);
                if (mem_ready && (cls_q == C_STORE)) begin
                    PCWr   = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                RUWr   = 1'b1;
                PCWr   = 1'b1;
                retire = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Field capture, MEM wait counter, retire counter, trap status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            aluop_q   <= '0;
            immsrc_q  <= '0;
            asrc_q    <= 1'b0;
            bsrc_q    <= 1'b0;
            dmctrl_q  <= '0;
            brop_q    <= '0;
            wrsrc_q   <= '0;
            cls_q     <= C_ALU;
            cnt_q     <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                aluop_q  <= dec_aluop;
                immsrc_q <= dec_immsrc;
                asrc_q   <= dec_asrc;
                bsrc_q   <= dec_bsrc;
                dmctrl_q <= dec_dmctrl;
                brop_q   <= dec_brop;
                wrsrc_q  <= dec_wrsrc;
                cls_q    <= dec_cls;
            end
            // Held at zero outside MEM, so every MEM visit starts from 0.
            if (state_q == S_MEM) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (retire) begin
                retired_q <= retired_q + RET_W'(1);
            end
            if (trap_set) begin
                trap_q  <= 1'b1;
                cause_q <= trap_cause_d;
            end
        end
    end

    assign retired    = retired_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_controlunit.md
Name: multicycle_controlunit

Overview:
- Multicycle successor to the single-cycle RV32I control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Registers the decoded control fields and qualifies all write strobes per state.
- Handshakes with instruction fetch and a variable-latency data memory, counts retired instructions, and traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: max cycles in MEM waiting for mem_ready before trap; legal range 2..2^CNT_W-1.
- CNT_W, 8: width of the memory-wait counter.
- RET_W, 32: width of the retired-instruction counter; wraps modulo 2^RET_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- OpCode  in  7  instruction opcode from IR.
- Funct3  in  3  from IR.
- Funct7  in  7  from IR.
- instr_valid  in  1  fetch data valid.
- mem_ready  in  1  data memory access complete.
- mul_done  in  1  multiplier/divider result valid; used only with the optional feature.
- IRWr  out  1  load instruction register.
- PCWr  out  1  update PC; next-PC select from BrOp.
- RUWr  out  1  register file write.
- DMWr  out  1  data memory write request.
- DMRd  out  1  data memory read request.
- ALUOp  out  4  ALU operation.
- ImmSrc  out  3  immediate format.
- ALUASrc  out  1  0=rs1, 1=PC.
- ALUBSrc  out  1  0=rs2, 1=imm.
- DMCtrl  out  3  = Funct3 of the load/store.
- BrOp  out  5  00xxx=none, 01{f3}=cond branch, 1xxxx=jump.
- RUDataWrSrc  out  2  00=ALU, 01=DM, 10=PC+4.
- mul_start  out  1  1-cycle start pulse to mul/div.
- retire  out  1  1-cycle pulse when an instruction completes.
- retired  out  RET_W  retired instruction count.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01=illegal opcode, 10=mem timeout.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to FETCH; all outputs are 0; retired=0; trap=0; trap_cause=00; wait counter=0.
  - Reset takes effect in any state, including mid-MEM.
- Decoded fields (ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMCtrl, BrOp, RUDataWrSrc) are registered on the DECODE cycle and held until the next DECODE.
- Decode table:
  - R (0110011): ALUOp={F7[5],F3}, B=0, WrSrc=00.
  - I-ALU (0010011): ALUOp={F3==101?F7[5]:0,F3}, B=1, ImmSrc=000.
  - Load (0000011): ALUOp=0000, B=1, ImmSrc=000, WrSrc=01.
  - Store (0100011): ImmSrc=001, B=1.
  - Branch (1100011): ImmSrc=101, BrOp={01,F3}, ALUOp=1000.
  - JAL (1101111): ImmSrc=110, A=1, B=1, BrOp=10000, WrSrc=10.
  - JALR (1100111): ImmSrc=000, B=1, BrOp=10000, WrSrc=10.
  - LUI (0110111): ImmSrc=010, ALUOp=1111 (pass B), B=1.
  - AUIPC (0010111): ImmSrc=010, A=1, B=1, ALUOp=0000.
  - Any other opcode is illegal.
- FETCH: wait while instr_valid=0. When instr_valid=1, IRWr=1 for that cycle, then go to DECODE.
- DECODE: 1 cycle. Illegal opcode goes to TRAP with cause 01; otherwise go to EXEC.
- EXEC: 1 cycle.
  - Load/store: go to MEM.
  - Branch: PCWr=1, retire=1, go to FETCH.
  - All others: go to WB.
- MEM:
  - DMRd (load) or DMWr (store) is held high every cycle in MEM.
  - Wait counter increments each cycle and clears on entry to MEM.
  - mem_ready=1: load goes to WB; store asserts PCWr=1 and retire=1, then goes to FETCH.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready=0: go to TRAP, cause 10, DMRd/DMWr drop next cycle.
  - mem_ready on the timeout cycle wins; no trap.
- WB: RUWr=1, PCWr=1, retire=1, go to FETCH.
- retired increments on each retire pulse and wraps from all-ones to 0.
- TRAP:
  - All strobes 0; trap=1; trap_cause held.
  - Leave only via rst; instr_valid is ignored.
- Latency (instr_valid to retire):
  - branch: 3 cycles.
  - ALU/jump/U: 4 cycles.
  - store: 3+N cycles; load: 4+N cycles, where N = MEM cycles (≥1).

Optional Feature:
- RV_M_EXT_EN defined:
  - OpCode 0110011 with Funct7=0000001 is legal; ALUOp={1,F3}, WrSrc=00.
  - EXEC pulses mul_start=1 and goes to MULWAIT.
  - MULWAIT holds until mul_done=1, then goes to WB.
  - No timeout applies in MULWAIT.
- Undefined:
  - Funct7=0000001 R-type is illegal (trap cause 01).
  - mul_start is tied 0 and mul_done is ignored.

Test Plan:
- Reset, then SUB (0110011/000/0100000) with instr_valid=1 → IRWr at t0; ALUOp=1000, ALUBSrc=0 from t1; RUWr=PCWr=retire=1 at t3; retired=1.
- ADDI (0010011/000) then BEQ (1100011/000) back-to-back → ADDI retires in 4 cycles with ALUBSrc=1; BEQ has BrOp=01000, ImmSrc=101, PCWr at t2, RUWr never asserted; retired=2.
- SW (0100011/010), mem_ready after 3 MEM cycles → DMWr high exactly 3 cycles, DMCtrl=010, retire on the third; LW with the same delay → RUWr one cycle after mem_ready, RUDataWrSrc=01.
- LW with mem_ready held 0, MEM_TIMEOUT=16 → DMRd high 16 cycles, trap=1, cause=10; further instr_valid is ignored; rst clears trap and retired.
- JAL (1101111) → ImmSrc=110, ALUASrc=1, BrOp=10000, RUDataWrSrc=10, RUWr at t3. Opcode 1111111 → trap cause 01 at t2, no RUWr/PCWr.
- With RV_M_EXT_EN, MUL (Funct7=0000001) and mul_done after 5 cycles → mul_start pulse at t2, RUWr at mul_done+1. Without the macro → trap cause 01.
